// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the fetch/PC sequencer.
//   - Opcode and funct encodings decoded by the next-PC logic.
//   - pc_state_t: the sequencer states FETCH / EXEC / HALT.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } pc_state_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// Bus bundle between pc_sequencer and its environment.
//   Instruction memory side: imem_req/imem_addr out, imem_ready/imem_data in.
//   Execute side: instr_valid/instr/pc out, ex_done/branch_taken/rs_content in.
//   Status: link_valid/link_addr (JAL return), retire_count, trap.
// master = the sequencer, slave = memory + execute path.
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_data;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] pc;
  logic              ex_done;
  logic              branch_taken;
  logic [31:0]       rs_content;
  logic              link_valid;
  logic [ADDR_W-1:0] link_addr;
  logic [31:0]       retire_count;
  logic              trap;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc,
           link_valid, link_addr, retire_count, trap,
    input  imem_ready, imem_data, ex_done, branch_taken, rs_content
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc,
           link_valid, link_addr, retire_count, trap,
    output imem_ready, imem_data, ex_done, branch_taken, rs_content
  );
endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC computation for the instruction in EXEC.
//   in : pc, instr, branch_taken, rs_content
//   out: next_pc, is_jal (link pulse request), misaligned (JR trap)
// Priority: J/JAL > JR > taken branch > sequential. All arithmetic wraps.
module next_pc_calc
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter bit BYTE_ADDR = 1'b0
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       instr,
  input  logic              branch_taken,
  input  logic [31:0]       rs_content,
  output logic [ADDR_W-1:0] next_pc,
  output logic              is_jal,
  output logic              misaligned
);
  localparam logic [ADDR_W-1:0] STEP = BYTE_ADDR ? ADDR_W'(4) : ADDR_W'(1);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] jump_pc;
  logic [ADDR_W-1:0] br_off;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  assign target = instr[25:0];
  assign seq    = pc + STEP;

  // Jump region bits come from seq, not pc, so a jump in the last slot of a
  // region lands in the following region.
  generate
    if (BYTE_ADDR) begin : g_byte
      if (ADDR_W > 28) begin : g_hi
        assign jump_pc = {seq[ADDR_W-1:28], target, 2'b00};
      end else begin : g_nohi
        assign jump_pc = {target, 2'b00};
      end
      assign br_off = {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
    end else begin : g_word
      assign jump_pc = {seq[ADDR_W-1:26], target};
      assign br_off  = {{(ADDR_W-16){imm[15]}}, imm};
    end
  endgenerate

  always_comb begin
    next_pc    = seq;
    is_jal     = 1'b0;
    misaligned = 1'b0;
    if (opcode == OP_J || opcode == OP_JAL) begin
      next_pc = jump_pc;
      is_jal  = (opcode == OP_JAL);
    end else if (opcode == OP_RTYPE && funct == FUNCT_JR) begin
      if (BYTE_ADDR && rs_content[1:0] != 2'b00) begin
        // PC stays put; the top turns this into a trap and HALT.
        next_pc    = pc;
        misaligned = 1'b1;
      end else begin
        next_pc = ADDR_W'(rs_content);
      end
    end else if (branch_taken) begin
      next_pc = seq + br_off;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/PC sequencer.
//   clock, reset : single clock, synchronous active-high reset
//   bus (master) : imem request/ready port, EXEC handshake (ex_done,
//                  branch_taken, rs_content), JAL link pulse,
//                  retire counter and sticky misaligned-target trap.
// FETCH holds imem_addr until imem_ready, EXEC waits for ex_done, HALT is
// terminal until reset.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter bit                BYTE_ADDR    = 1'b0
) (
  input logic           clock,
  input logic           reset,
  pc_sequencer_if.master bus
);
  localparam logic [ADDR_W-1:0] STEP = BYTE_ADDR ? ADDR_W'(4) : ADDR_W'(1);

  pc_state_t         state, state_nxt;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       instr_q;
  logic [31:0]       retire_q;
  logic              trap_q;
  logic              link_q;
  logic [ADDR_W-1:0] link_addr_q;

  logic [ADDR_W-1:0] next_pc;
  logic              is_jal;
  logic              misaligned;
  logic              retire;

  next_pc_calc #(
    .ADDR_W   (ADDR_W),
    .BYTE_ADDR(BYTE_ADDR)
  ) u_next_pc (
    .pc          (pc_q),
    .instr       (instr_q),
    .branch_taken(bus.branch_taken),
    .rs_content  (bus.rs_content),
    .next_pc     (next_pc),
    .is_jal      (is_jal),
    .misaligned  (misaligned)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (bus.imem_ready) state_nxt = EXEC;
      EXEC:    if (bus.ex_done) state_nxt = misaligned ? HALT : FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  // A misaligned JR does not retire: no PC update, no count, no link.
  assign retire = (state == EXEC) && bus.ex_done && !misaligned;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FETCH;
      pc_q        <= RESET_VECTOR;
      instr_q     <= '0;
      retire_q    <= '0;
      trap_q      <= 1'b0;
      link_q      <= 1'b0;
      link_addr_q <= '0;
    end else begin
      state  <= state_nxt;
      link_q <= 1'b0;
      if (state == FETCH && bus.imem_ready) instr_q <= bus.imem_data;
      if (state == EXEC && bus.ex_done && misaligned) trap_q <= 1'b1;
      if (retire) begin
        pc_q     <= next_pc;
        retire_q <= retire_q + 32'd1;
        link_q   <= is_jal;
        if (is_jal) link_addr_q <= pc_q + STEP;
      end
    end
  end

  assign bus.imem_req     = (state == FETCH);
  assign bus.instr_valid  = (state == EXEC);
  assign bus.imem_addr    = pc_q;
  assign bus.pc           = pc_q;
  assign bus.instr        = instr_q;
  assign bus.link_valid   = link_q;
  assign bus.link_addr    = link_addr_q;
  assign bus.retire_count = retire_q;
  assign bus.trap         = trap_q;
endmodule
